// File: rtl/mdr_mem_port.sv
// Memory data register (BusMuxIn_MDR) loadable from the bus or from memory through a
// req/ack handshake with timeout, byte/half/word lane steering and optional sign extension.
module mdr_mem_port #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [DATA_W-1:0]           bus_in,
  input  logic                        mdr_in,
  input  logic                        rd_start,
  input  logic                        wr_start,
  input  logic [1:0]                  size,
  input  logic                        sign_ext,
  input  logic [$clog2(DATA_W/8)-1:0] byte_off,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [DATA_W/8-1:0]         mem_be,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W-1:0]           mdr_q,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int NB    = DATA_W / 8;
  localparam int BO_W  = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mdr_d;
  logic              isWr_q, isWr_d;
  logic [1:0]        accSize_q, accSize_d;
  logic              signExt_q, signExt_d;
  logic [BO_W-1:0]   byteOff_q, byteOff_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              startRd, startWr, start;
  logic              lastCycle;

  function automatic logic [NB-1:0] laneEnables(input logic [1:0] sz, input logic [BO_W-1:0] off);
    case (sz)
      2'b00:   laneEnables = NB'(1) << off;
      2'b01:   laneEnables = NB'(3) << {off[BO_W-1:1], 1'b0};
      default: laneEnables = '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] steerWrite(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    case (sz)
      2'b00:   steerWrite = {NB{d[7:0]}};
      2'b01:   steerWrite = {(NB/2){d[15:0]}};
      default: steerWrite = d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] formatRead(input logic [1:0] sz, input logic sx,
                                                   input logic [BO_W-1:0] off,
                                                   input logic [DATA_W-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[BO_W-1:1], 4'b0000} +: 16];
    case (sz)
      2'b00:   formatRead = {{(DATA_W-8){sx & b[7]}}, b};
      2'b01:   formatRead = {{(DATA_W-16){sx & h[15]}}, h};
      default: formatRead = rdata;
    endcase
  endfunction

  assign startRd   = (state_q == IDLE) && rd_start;
  assign startWr   = (state_q == IDLE) && !rd_start && wr_start;
  assign start     = startRd || startWr;
  assign lastCycle = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (mem_ack || lastCycle) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: ;
      WAIT: begin
        mem_req = 1'b1;
        mem_we  = isWr_q;
        busy    = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Write data is captured from the pre-load mdr_q, so a same-cycle mdr_in never leaks into it.
  always_comb begin
    mdr_d     = mdr_q;
    cnt_d     = cnt_q;
    isWr_d    = isWr_q;
    accSize_d = accSize_q;
    signExt_d = signExt_q;
    byteOff_d = byteOff_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (mdr_in && !rd_start) mdr_d = bus_in;
        if (start) begin
          isWr_d    = startWr;
          accSize_d = size;
          signExt_d = sign_ext;
          byteOff_d = byte_off;
          be_d      = laneEnables(size, byte_off);
          err_d     = 1'b0;
          cnt_d     = '0;
          if (startWr) wdata_d = steerWrite(size, mdr_q);
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (!isWr_q) mdr_d = formatRead(accSize_q, signExt_q, byteOff_q, mem_rdata);
        end else if (lastCycle) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q     <= '0;
      mdr_q     <= '0;
      isWr_q    <= 1'b0;
      accSize_q <= 2'b00;
      signExt_q <= 1'b0;
      byteOff_q <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mdr_q     <= mdr_d;
      isWr_q    <= isWr_d;
      accSize_q <= accSize_d;
      signExt_q <= signExt_d;
      byteOff_q <= byteOff_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
    end
  end

  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Self-checking bench for mdr_mem_port: directed scenarios plus randomized transactions
// checked against a behavioural model of the MDR and the memory handshake.
module tb_mdr_mem_port;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        mdr_in, rd_start, wr_start;
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  byte_off;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mdr_q;
  logic        busy, done, err;

  mdr_mem_port #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .mdr_in(mdr_in), .rd_start(rd_start),
    .wr_start(wr_start), .size(size), .sign_ext(sign_ext), .byte_off(byte_off),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mdr_q(mdr_q), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] modelMdr;

  // Observations recorded by runXact for the calling test
  int          reqCycles, doneCount, doneIdx, idleIdx;
  bit          hung;
  logic        weSeen, errFirst;
  logic [3:0]  beSeen;
  logic [31:0] wdSeen, mdrAfterStart;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] refRead(input logic [31:0] rdata, input logic [1:0] sz,
                                          input bit sx, input int off);
    logic [31:0] v;
    int lane;
    if (sz == 2'd0) begin
      v = (rdata >> (8 * off)) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      lane = (off / 2) * 2;
      v = (rdata >> (8 * lane)) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] refBe(input logic [1:0] sz, input int off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] refWdata(input logic [1:0] sz, input logic [31:0] m);
    if (sz == 2'd0) return (m & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (m & 32'hFFFF) * 32'h0001_0001;
    return m;
  endfunction

  task automatic idleInputs();
    mdr_in = 0; rd_start = 0; wr_start = 0; mem_ack = 0;
  endtask

  task automatic loadMdr(input logic [31:0] v);
    mdr_in = 1; bus_in = v;
    cycle();
    mdr_in = 0;
    modelMdr = v;
  endtask

  // Drives one start cycle then plays the memory side; ackAt=k acks in the k-th request cycle, 0 never acks
  task automatic runXact(input bit rdS, input bit wrS, input bit ldS, input logic [31:0] busVal,
                         input logic [1:0] sz, input bit sx, input logic [1:0] off,
                         input logic [31:0] rdata, input int ackAt, input bit noise);
    reqCycles = 0; doneCount = 0; doneIdx = -1; idleIdx = -1; hung = 1'b1;
    rd_start = rdS; wr_start = wrS; mdr_in = ldS; bus_in = busVal;
    size = sz; sign_ext = sx; byte_off = off; mem_rdata = rdata; mem_ack = 0;
    cycle();
    rd_start = 0; wr_start = 0; mdr_in = 0;
    mdrAfterStart = mdr_q; errFirst = err; weSeen = mem_we; beSeen = mem_be; wdSeen = mem_wdata;
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      if (!busy) begin
        idleIdx = i;
        hung = 1'b0;
        break;
      end
      if (done) begin
        doneCount++;
        doneIdx = i;
      end
      if (mem_req) reqCycles++;
      mem_ack = mem_req ? (reqCycles == ackAt) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      if (noise) begin
        mdr_in = 1'($urandom_range(0, 1)); rd_start = 1'($urandom_range(0, 1));
        wr_start = 1'($urandom_range(0, 1)); bus_in = $urandom;
        size = 2'($urandom_range(0, 3)); byte_off = 2'($urandom_range(0, 3));
        sign_ext = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    idleInputs();
    if (hung) begin
      clr = 1; cycle(); clr = 0;
      modelMdr = 0;
    end
  endtask

  task automatic test_reset();
    idleInputs(); bus_in = 0; size = 0; sign_ext = 0; byte_off = 0; mem_rdata = 0;
    clr = 1;
    cycle(); cycle();
    clr = 0;
    checks++; if (mdr_q !== 32'h0) begin failures++; $display("[TB] FAIL reset_mdr got %h want 00000000", mdr_q); end
    checks++; if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin failures++; $display("[TB] FAIL reset_ctrl got req/we/busy/done/err=%b want 00000", {mem_req, mem_we, busy, done, err}); end
    checks++; if (mem_be !== 4'h0 || mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_lanes got be=%h wdata=%h want 0/0", mem_be, mem_wdata); end
    cycle();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    modelMdr = 0;
    loadMdr(32'hDEAD_BEEF);
    checks++; if (mdr_q !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL mdr_load got %h want deadbeef", mdr_q); end
  endtask

  task automatic test_word_read();
    runXact(1, 0, 0, 0, 2'b10, 0, 0, 32'h1234_5678, 3, 0);
    checks++; if (hung) begin failures++; $display("[TB] FAIL word_read_hang got busy stuck want idle"); end
    checks++; if (weSeen !== 1'b0 || beSeen !== 4'hF) begin failures++; $display("[TB] FAIL word_read_we_be got we=%b be=%h want 0/f", weSeen, beSeen); end
    checks++; if (reqCycles != 3) begin failures++; $display("[TB] FAIL word_read_req got %0d want 3", reqCycles); end
    checks++; if (doneCount != 1 || doneIdx != 3) begin failures++; $display("[TB] FAIL word_read_done got count=%0d idx=%0d want 1/3", doneCount, doneIdx); end
    checks++; if (idleIdx != 4) begin failures++; $display("[TB] FAIL word_read_busy_fall got %0d want 4", idleIdx); end
    modelMdr = 32'h1234_5678;
    checks++; if (mdr_q !== modelMdr || err !== 1'b0) begin failures++; $display("[TB] FAIL word_read_data got mdr=%h err=%b want %h/0", mdr_q, err, modelMdr); end
  endtask

  task automatic test_signed_byte();
    logic [1:0] szs [3] = '{2'b00, 2'b00, 2'b01};
    bit         sxs [3] = '{1, 0, 1};
    logic [1:0] offs[3] = '{2'd2, 2'd2, 2'd3};
    logic [31:0] exps[3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF};
    for (int k = 0; k < 3; k++) begin
      runXact(1, 0, 0, 0, szs[k], sxs[k], offs[k], 32'h80FF_7F01, 1, 0);
      modelMdr = refRead(32'h80FF_7F01, szs[k], sxs[k], int'(offs[k]));
      checks++; if (mdr_q !== exps[k]) begin failures++; $display("[TB] FAIL subword_read_%0d got %h want %h", k, mdr_q, exps[k]); end
      checks++; if (beSeen !== refBe(szs[k], int'(offs[k]))) begin failures++; $display("[TB] FAIL subword_be_%0d got %b want %b", k, beSeen, refBe(szs[k], int'(offs[k]))); end
    end
  endtask

  task automatic test_half_write();
    loadMdr(32'h0000_ABCD);
    runXact(0, 1, 0, 0, 2'b01, 0, 2'd2, 32'h5555_5555, 2, 0);
    checks++; if (weSeen !== 1'b1 || beSeen !== 4'b1100) begin failures++; $display("[TB] FAIL half_write_we_be got we=%b be=%b want 1/1100", weSeen, beSeen); end
    checks++; if (wdSeen !== 32'hABCD_ABCD) begin failures++; $display("[TB] FAIL half_write_data got %h want abcdabcd", wdSeen); end
    checks++; if (mdr_q !== 32'h0000_ABCD || doneCount != 1) begin failures++; $display("[TB] FAIL half_write_after got mdr=%h done=%0d want 0000abcd/1", mdr_q, doneCount); end
  endtask

  task automatic test_timeout();
    loadMdr(32'h1111_2222);
    runXact(1, 0, 0, 0, 2'b10, 0, 0, 32'h9999_9999, 0, 0);
    checks++; if (reqCycles != TIMEOUT) begin failures++; $display("[TB] FAIL timeout_req got %0d want %0d", reqCycles, TIMEOUT); end
    checks++; if (doneCount != 1 || doneIdx != TIMEOUT) begin failures++; $display("[TB] FAIL timeout_done got count=%0d idx=%0d want 1/%0d", doneCount, doneIdx, TIMEOUT); end
    checks++; if (err !== 1'b1 || mdr_q !== modelMdr) begin failures++; $display("[TB] FAIL timeout_err got err=%b mdr=%h want 1/%h", err, mdr_q, modelMdr); end
    runXact(1, 0, 0, 0, 2'b10, 0, 0, 32'h7777_0001, TIMEOUT, 0);
    modelMdr = 32'h7777_0001;
    checks++; if (errFirst !== 1'b0) begin failures++; $display("[TB] FAIL timeout_err_clear got %b want 0", errFirst); end
    checks++; if (reqCycles != TIMEOUT || err !== 1'b0 || mdr_q !== modelMdr) begin failures++; $display("[TB] FAIL last_cycle_ack got req=%0d err=%b mdr=%h want %0d/0/%h", reqCycles, err, mdr_q, TIMEOUT, modelMdr); end
  endtask

  task automatic test_conflict();
    logic [31:0] old;
    loadMdr(32'h0BAD_F00D);
    runXact(1, 1, 1, 32'hCAFE_F00D, 2'b10, 0, 0, 32'h1357_2468, 1, 0);
    checks++; if (weSeen !== 1'b0) begin failures++; $display("[TB] FAIL conflict_we got %b want 0", weSeen); end
    checks++; if (mdrAfterStart !== 32'h0BAD_F00D) begin failures++; $display("[TB] FAIL conflict_no_load got %h want 0badf00d", mdrAfterStart); end
    modelMdr = 32'h1357_2468;
    checks++; if (mdr_q !== modelMdr) begin failures++; $display("[TB] FAIL conflict_read got %h want %h", mdr_q, modelMdr); end
    old = modelMdr;
    runXact(0, 1, 1, 32'h2468_ACE0, 2'b10, 0, 0, 32'h0, 1, 0);
    modelMdr = 32'h2468_ACE0;
    checks++; if (wdSeen !== old || weSeen !== 1'b1) begin failures++; $display("[TB] FAIL write_old_mdr got wdata=%h we=%b want %h/1", wdSeen, weSeen, old); end
    checks++; if (mdr_q !== modelMdr) begin failures++; $display("[TB] FAIL write_with_load got %h want %h", mdr_q, modelMdr); end
  endtask

  task automatic test_clr_mid_wait();
    int doneSeen = 0;
    loadMdr(32'h4242_4242);
    rd_start = 1; size = 2'b10; mem_rdata = 32'h3333_3333;
    cycle();
    rd_start = 0;
    cycle();
    clr = 1; mem_ack = 1;
    cycle();
    clr = 0; mem_ack = 0;
    modelMdr = 0;
    checks++; if ({busy, mem_req, done} !== 3'b000) begin failures++; $display("[TB] FAIL clr_wait_ctrl got busy/req/done=%b want 000", {busy, mem_req, done}); end
    for (int i = 0; i < 3; i++) begin
      if (done) doneSeen++;
      cycle();
    end
    checks++; if (doneSeen != 0 || mdr_q !== modelMdr) begin failures++; $display("[TB] FAIL clr_wait_after got done=%0d mdr=%h want 0/%h", doneSeen, mdr_q, modelMdr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit rd = 1'($urandom_range(0, 1));
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [1:0] off = 2'($urandom_range(0, 3));
      bit sx = 1'($urandom_range(0, 1));
      logic [31:0] rdata = $urandom;
      int ackAt = $urandom_range(0, TIMEOUT);
      int expReq = (ackAt == 0) ? TIMEOUT : ackAt;
      logic [31:0] preMdr;
      if ($urandom_range(0, 1) == 1) loadMdr($urandom);
      preMdr = modelMdr;
      runXact(rd, !rd, 0, 0, sz, sx, off, rdata, ackAt, 1);
      if (rd && ackAt != 0) modelMdr = refRead(rdata, sz, sx, int'(off));
      checks++; if (hung || reqCycles != expReq || doneCount != 1 || idleIdx != expReq + 1) begin failures++; $display("[TB] FAIL rand_%0d_timing got hung=%b req=%0d done=%0d idle=%0d want 0/%0d/1/%0d", n, hung, reqCycles, doneCount, idleIdx, expReq, expReq + 1); end
      checks++; if (weSeen !== !rd || beSeen !== refBe(sz, int'(off))) begin failures++; $display("[TB] FAIL rand_%0d_we_be got we=%b be=%b want %b/%b", n, weSeen, beSeen, !rd, refBe(sz, int'(off))); end
      if (!rd) begin
        checks++; if (wdSeen !== refWdata(sz, preMdr)) begin failures++; $display("[TB] FAIL rand_%0d_wdata got %h want %h", n, wdSeen, refWdata(sz, preMdr)); end
      end
      checks++; if (errFirst !== 1'b0 || err !== (ackAt == 0)) begin failures++; $display("[TB] FAIL rand_%0d_err got start=%b end=%b want 0/%b", n, errFirst, err, ackAt == 0); end
      checks++; if (mdr_q !== modelMdr) begin failures++; $display("[TB] FAIL rand_%0d_mdr got %h want %h", n, mdr_q, modelMdr); end
    end
  endtask

  initial begin
    clr = 1; idleInputs();
    test_reset();
    test_word_read();
    test_signed_byte();
    test_half_write();
    test_timeout();
    test_conflict();
    test_clr_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
